// File: rtl/div_pkg.sv
// Shared types and constants for the divider request scheduler.
package div_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  // Quotient reported for a divide-by-zero; all ones in every bit.
  localparam logic [DIV_W-1:0] DIV0_COC = '1;

endpackage

// File: rtl/div_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting for the divider and, on expiry,
// drives a registered active-low abort for exactly two cycles.
module div_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1 << 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  input  logic done_i,
  output logic expire_o,
  output logic busy_o,
  output logic last_o,
  output logic abort_n_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      abort_cnt_q, abort_cnt_d;
  logic            abort_n_q, abort_n_d;

  assign busy_o    = (abort_cnt_q != 2'd0);
  assign last_o    = (abort_cnt_q == 2'd1);
  // Expire after TIMEOUT_CYC full cycles in WAIT; a done on the same edge wins.
  assign expire_o  = run_i && !done_i && !busy_o && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign abort_n_o = abort_n_q;

  always_comb begin
    cnt_d       = cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && !busy_o && (cnt_q != CntW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expire_o) begin
      abort_cnt_d = 2'd2;
    end else if (busy_o) begin
      abort_cnt_d = abort_cnt_q - 2'd1;
    end
    abort_n_d = (abort_cnt_d == 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      abort_cnt_q <= 2'd0;
      abort_n_q   <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      abort_cnt_q <= abort_cnt_d;
      abort_n_q   <= abort_n_d;
    end
  end

endmodule

// File: rtl/div_request_scheduler.sv
// Sequencer in front of the multi-cycle signed divider: one operation in flight,
// divide-by-zero screening, result held until consumed. Define DIV_TIMEOUT_EN for a WAIT watchdog.
module div_request_scheduler
  import div_pkg::*;
#(
  parameter int unsigned W           = DIV_W,
  parameter int unsigned TIMEOUT_CYC = 1 << 20
) (
  input  logic         CLK,
  input  logic         RSTa,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_den,
  output logic         div_start,
  output logic [W-1:0] div_num,
  output logic [W-1:0] div_den,
  input  logic [W-1:0] div_coc,
  input  logic [W-1:0] div_res,
  input  logic         div_done,
  output logic         div_rst_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_coc,
  output logic [W-1:0] out_res,
  output logic         out_err,
  output logic         out_timeout
);

  state_t       state_q, state_d;
  logic [W-1:0] div_num_q, div_num_d;
  logic [W-1:0] div_den_q, div_den_d;
  logic [W-1:0] out_coc_q, out_coc_d;
  logic [W-1:0] out_res_q, out_res_d;
  logic         out_err_q, out_err_d;
  logic         out_timeout_q, out_timeout_d;

  logic abort_n;
  logic wd_expire;
  logic wd_busy;
  logic wd_last;

`ifdef DIV_TIMEOUT_EN
  div_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (CLK),
    .rst_ni   (RSTa),
    .clear_i  (state_q == ISSUE),
    .run_i    (state_q == WAIT),
    .done_i   (div_done),
    .expire_o (wd_expire),
    .busy_o   (wd_busy),
    .last_o   (wd_last),
    .abort_n_o(abort_n)
  );
`else
  assign wd_expire = 1'b0;
  assign wd_busy   = 1'b0;
  assign wd_last   = 1'b0;
  assign abort_n   = 1'b1;

  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  assign in_ready    = (state_q == IDLE);
  assign div_start   = (state_q == ISSUE);
  assign out_valid   = (state_q == HOLD);
  assign div_num     = div_num_q;
  assign div_den     = div_den_q;
  assign out_coc     = out_coc_q;
  assign out_res     = out_res_q;
  assign out_err     = out_err_q;
  assign out_timeout = out_timeout_q;
  assign div_rst_n   = RSTa & abort_n;

  always_comb begin
    state_d       = state_q;
    div_num_d     = div_num_q;
    div_den_d     = div_den_q;
    out_coc_d     = out_coc_q;
    out_res_d     = out_res_q;
    out_err_d     = out_err_q;
    out_timeout_d = out_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_num_d     = in_num;
          div_den_d     = in_den;
          out_timeout_d = 1'b0;
          if (in_den == '0) begin
            // Package constant is all ones; replicate its bit to fit any W.
            out_coc_d = {W{DIV0_COC[0]}};
            out_res_d = in_num;
            out_err_d = 1'b1;
            state_d   = HOLD;
          end else begin
            out_err_d = 1'b0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // While the divider is being aborted its done output is meaningless.
        if (wd_busy) begin
          if (wd_last) begin
            state_d = HOLD;
          end
        end else if (div_done) begin
          out_coc_d = div_coc;
          out_res_d = div_res;
          state_d   = HOLD;
        end else if (wd_expire) begin
          out_timeout_d = 1'b1;
          out_coc_d     = '0;
          out_res_d     = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q       <= IDLE;
      div_num_q     <= '0;
      div_den_q     <= '0;
      out_coc_q     <= '0;
      out_res_q     <= '0;
      out_err_q     <= 1'b0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_num_q     <= div_num_d;
      div_den_q     <= div_den_d;
      out_coc_q     <= out_coc_d;
      out_res_q     <= out_res_d;
      out_err_q     <= out_err_d;
      out_timeout_q <= out_timeout_d;
    end
  end

endmodule

// File: tb/tb_div_request_scheduler.sv
// Directed bench for div_request_scheduler with a behavioural divider stub.
module tb_div_request_scheduler;

  localparam int unsigned TbTimeout = 16;

  logic        CLK = 1'b0;
  logic        RSTa;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_num = '0;
  logic [31:0] in_den = '0;
  logic        div_start;
  logic [31:0] div_num, div_den;
  logic [31:0] div_coc, div_res;
  logic        div_done;
  logic        div_rst_n;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_coc, out_res;
  logic        out_err, out_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  div_request_scheduler #(
    .W          (32),
    .TIMEOUT_CYC(TbTimeout)
  ) dut (
    .CLK        (CLK),
    .RSTa       (RSTa),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_den     (in_den),
    .div_start  (div_start),
    .div_num    (div_num),
    .div_den    (div_den),
    .div_coc    (div_coc),
    .div_res    (div_res),
    .div_done   (div_done),
    .div_rst_n  (div_rst_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coc    (out_coc),
    .out_res    (out_res),
    .out_err    (out_err),
    .out_timeout(out_timeout)
  );

  // Divider stub: done pulses 2*|q|+3 cycles after Start; reset by div_rst_n.
  logic        m_busy, m_done;
  logic [31:0] m_q, m_r;
  int          m_cnt;
  logic        stray_done = 1'b0;

  assign div_done = m_done | stray_done;
  assign div_coc  = stray_done ? 32'hDEAD_BEEF : m_q;
  assign div_res  = stray_done ? 32'h0BAD_F00D : m_r;

  always @(posedge CLK or negedge div_rst_n) begin
    if (!div_rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start) begin
        logic signed [31:0] q;
        q = (div_den == 0) ? 0 : $signed(div_num) / $signed(div_den);
        m_q    <= q;
        m_r    <= (div_den == 0) ? 0 : $signed(div_num) % $signed(div_den);
        m_cnt  <= 2 * ((q < 0) ? -q : q) + 3;
        m_busy <= 1'b1;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request, wait for the result, check it, optionally consume it.
  task automatic run_op(input logic [31:0] num, input logic [31:0] den,
                        input logic [31:0] exp_coc, input logic [31:0] exp_res,
                        input logic exp_err, input logic exp_to, input int exp_starts,
                        input int exp_lat, input bit release_it, input string name);
    int cyc;
    int starts;
    int aborts;
    bit got;
    @(negedge CLK);
    in_valid = 1'b1;
    in_num   = num;
    in_den   = den;
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    starts = 0;
    aborts = 0;
    got    = 0;
    for (cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        chk({name, "_div_num"}, div_num, num);
        chk({name, "_div_den"}, div_den, den);
      end
      if (div_start) starts++;
      if (!div_rst_n) aborts++;
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    chk({name, "_out_valid"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({name, "_coc"}, out_coc, exp_coc);
      chk({name, "_res"}, out_res, exp_res);
      chk({name, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
      chk({name, "_timeout"}, {31'b0, out_timeout}, {31'b0, exp_to});
      chk({name, "_starts"}, starts, exp_starts);
      chk({name, "_in_ready_hold"}, {31'b0, in_ready}, 32'd0);
      chk({name, "_num_stable"}, div_num, num);
      if (exp_to) chk({name, "_abort_cycles"}, aborts, 32'd2);
      if (exp_lat >= 0) chk({name, "_latency"}, cyc, exp_lat);
    end
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge CLK);
      #1 out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] coc;
    logic [31:0] res;
    logic        err;
    int          starts;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] held_coc, held_res;
    bit          stable;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1, -1, "p100_p7"};
    vecs[1] = '{-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1, -1, "m100_p7"};
    vecs[2] = '{32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1, -1, "p100_m7"};
    vecs[3] = '{-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 1, -1, "m100_m7"};
    vecs[4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 1, "p5_div0"};
    vecs[5] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1, -1, "p9_p3"};
    vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1, -1, "p0_p5"};
    vecs[7] = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1, -1, "p7_p100"};

    // Reset
    RSTa = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_div_start", {31'b0, div_start}, 32'd0);
    chk("rst_div_rst_n", {31'b0, div_rst_n}, 32'd1);
    chk("rst_out_coc", out_coc, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_out_timeout", {31'b0, out_timeout}, 32'd0);

    // Stray done while idle is ignored
    stray_done = 1'b1;
    @(negedge CLK);
    stray_done = 1'b0;
    @(negedge CLK);
    chk("stray_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("stray_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("stray_idle_coc", out_coc, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].num, vecs[i].den, vecs[i].coc, vecs[i].res, vecs[i].err, 1'b0,
             vecs[i].starts, vecs[i].lat, 1'b1, vecs[i].name);
    end

    // Stall in HOLD for 10 cycles with a stray done, then back-to-back request
    run_op(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 1'b0, 1, -1, 1'b0, "stall_50_6");
    held_coc = out_coc;
    held_res = out_res;
    stable   = 1;
    for (int k = 0; k < 10; k++) begin
      stray_done = (k == 4);
      @(negedge CLK);
      if (out_coc !== held_coc || out_res !== held_res || !out_valid || in_ready) stable = 0;
    end
    stray_done = 1'b0;
    chk("stall_stable", {31'b0, stable}, 32'd1);
    chk("stall_coc", out_coc, 32'd8);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_num    = 32'd9;
    in_den    = 32'd3;
    chk("handshake_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    chk("after_hs_ready", {31'b0, in_ready}, 32'd1);
    chk("after_hs_valid", {31'b0, out_valid}, 32'd0);
    chk("after_hs_start", {31'b0, div_start}, 32'd0);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    @(negedge CLK);
    chk("next_req_start", {31'b0, div_start}, 32'd1);
    begin
      bit got2;
      got2 = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge CLK);
        if (out_valid) begin
          got2 = 1;
          break;
        end
      end
      chk("next_req_valid", {31'b0, got2}, 32'd1);
      chk("next_req_coc", out_coc, 32'd3);
      chk("next_req_res", out_res, 32'd0);
      out_ready = 1'b1;
      @(posedge CLK);
      #1 out_ready = 1'b0;
    end

    // Reset mid-operation drops the result and resets the divider
    @(negedge CLK);
    in_valid = 1'b1;
    in_num   = 32'd1000;
    in_den   = 32'd1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    RSTa = 1'b0;
    #1;
    chk("midrst_div_rst_n", {31'b0, div_rst_n}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_div_rst_n_rel", {31'b0, div_rst_n}, 32'd1);
    run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1, -1, 1'b1, "after_rst_7_2");

`ifdef DIV_TIMEOUT_EN
    run_op(32'd1000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1, -1, 1'b1, "timeout_1000_1");
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1, -1, 1'b1, "post_to_9_3");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
